// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between four byte-wide requesters, the write arbiter and the shared FIFO.
// The arbiter uses the slave modport; the requester/FIFO side uses the master modport.
interface fifo_wr_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;

  modport master (
    output req, req_data, req_last, fifo_full,
    input  gnt, ack, busy, fifo_wr_en, fifo_data
  );

  modport slave (
    input  req, req_data, req_last, fifo_full,
    output gnt, ack, busy, fifo_wr_en, fifo_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one of four requesters the shared FIFO for a
// burst of up to BURST_MAX beats, with one idle arbitration cycle between grants.
module fifo_wr_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, OWN} state_e;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] last_id_q, last_id_d;

  logic       own;
  logic       owner_req;
  logic       owner_last;
  logic [7:0] owner_data;
  logic       wr_en;
  logic       pick_vld;
  logic [1:0] pick_id;

  // In OWN, last_id_q always holds the current owner's index.
  assign own        = (state_q == OWN);
  assign owner_req  = bus.req[last_id_q];
  assign owner_last = bus.req_last[last_id_q];
  assign owner_data = bus.req_data[{last_id_q, 3'b000} +: 8];
  assign wr_en      = own & owner_req & ~bus.fifo_full;

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick_vld = 1'b0;
    pick_id  = last_id_q;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_vld && bus.req[last_id_q + 2'(i)]) begin
        pick_vld = 1'b1;
        pick_id  = last_id_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    last_id_d  = last_id_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = OWN;
          gnt_d      = 4'b0001 << pick_id;
          busy_d     = 1'b1;
          last_id_d  = pick_id;
          beat_cnt_d = 4'd0;
        end
      end
      OWN: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end else if (wr_en) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (owner_last || (beat_cnt_q + 4'd1 == BURST_LIM)) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end
        // fifo_full with req held: stall, everything keeps its value.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      busy_q     <= 1'b0;
      beat_cnt_q <= 4'd0;
      last_id_q  <= 2'd3;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      last_id_q  <= last_id_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_data  = own ? owner_data : 8'h00;
  assign bus.ack        = gnt_q & {4{wr_en}};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: behavioural requesters feed per-port byte
// queues, expected FIFO writes are queued in order and matched as they appear.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if bus ();

  fifo_wr_arbiter #(.BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] src_data[4][$];
  logic       src_last[4][$];
  logic [3:0] req_en;
  logic [3:0] ack_seen;
  int         ack_cnt[4];
  int         grant_log[$];
  int         gap_log[$];
  int         idle_run;
  logic [3:0] prev_gnt;
  beat_t      mon_exp;
  logic       mon_exp_wr;
  int         checks = 0;
  int         errors = 0;

  function automatic int idx_of(logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      if (req_en[i] && src_data[i].size() > 0) begin
        bus.req[i]            = 1'b1;
        bus.req_data[8*i +: 8] = src_data[i][0];
        bus.req_last[i]       = src_last[i][0];
      end else begin
        bus.req[i]            = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic last);
    src_data[i].push_back(d);
    src_last[i].push_back(last);
  endtask

  task automatic push_exp(input int i, input logic [7:0] d);
    beat_t b;
    b.id   = 2'(i);
    b.data = d;
    sb.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, sb.size(), max_cycles);
      sb.delete();
    end
  endtask

  task automatic wait_ack(input string name, input int i, input int cnt, input int max_cycles);
    int n = 0;
    while (ack_cnt[i] < cnt && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (ack_cnt[i] < cnt) begin
      errors++;
      $display("FAIL %s_ack_timeout: ack count %0d required %0d", name, ack_cnt[i], cnt);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.fifo_full = 1'b0;
    req_en        = 4'hF;
    for (int i = 0; i < 4; i++) begin
      src_data[i].delete();
      src_last[i].delete();
    end
    sb.delete();
    drive_reqs();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    grant_log.delete();
    gap_log.delete();
  endtask

  // Requester side: retire a beat only after the edge that wrote it.
  initial begin
    ack_seen = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (ack_seen[i] && src_data[i].size() > 0) begin
          void'(src_data[i].pop_front());
          void'(src_last[i].pop_front());
        end
      ack_seen = 4'h0;
      drive_reqs();
    end
  end

  // FIFO side monitor, sampled mid-cycle.
  initial begin
    prev_gnt = 4'h0;
    idle_run = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (!$onehot0(bus.gnt)) begin
        errors++;
        $display("FAIL gnt_onehot: gnt %b not one-hot or zero", bus.gnt);
      end
      checks++;
      if (bus.busy !== (bus.gnt != 4'h0)) begin
        errors++;
        $display("FAIL busy_vs_gnt: busy %b with gnt %b", bus.busy, bus.gnt);
      end
      mon_exp_wr = (bus.gnt != 4'h0) && ((bus.req & bus.gnt) != 4'h0) && !bus.fifo_full;
      checks++;
      if (bus.fifo_wr_en !== mon_exp_wr) begin
        errors++;
        $display("FAIL wr_en: got %b required %b (gnt %b req %b full %b)",
                 bus.fifo_wr_en, mon_exp_wr, bus.gnt, bus.req, bus.fifo_full);
      end
      if (bus.fifo_wr_en === 1'b1) begin
        ack_seen = bus.ack;
        for (int i = 0; i < 4; i++) if (bus.ack[i]) ack_cnt[i]++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: data %h ack %b", bus.fifo_data, bus.ack);
        end else begin
          mon_exp = sb.pop_front();
          if (bus.fifo_data !== mon_exp.data || bus.ack !== (4'b0001 << mon_exp.id)) begin
            errors++;
            $display("FAIL write_beat: got data %h ack %b required data %h ack %b",
                     bus.fifo_data, bus.ack, mon_exp.data, 4'b0001 << mon_exp.id);
          end
        end
      end else begin
        checks++;
        if (bus.ack !== 4'h0) begin
          errors++;
          $display("FAIL ack_no_write: ack %b required 0000", bus.ack);
        end
      end
      if (bus.gnt == 4'h0) begin
        checks++;
        if (bus.fifo_data !== 8'h00) begin
          errors++;
          $display("FAIL idle_data: fifo_data %h required 00", bus.fifo_data);
        end
        idle_run++;
      end else begin
        if (prev_gnt == 4'h0) begin
          grant_log.push_back(idx_of(bus.gnt));
          gap_log.push_back(idle_run);
        end
        idle_run = 0;
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.fifo_full = 1'b0;
    req_en = 4'hF;
    drive_reqs();
    step();
    step();
    load(0, 8'h5A, 1'b1);
    drive_reqs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'h0 || bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.ack !== 4'h0) begin
        errors++;
        $display("FAIL reset_hold: gnt %b busy %b wr_en %b ack %b required 0000 0 0 0000",
                 bus.gnt, bus.busy, bus.fifo_wr_en, bus.ack);
      end
    end
    step();
    push_exp(0, 8'h5A);
    grant_log.delete();
    rst = 1'b0;
    wait_done("reset_release", 20);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      errors++;
      $display("FAIL reset_first_grant: grants %0d first %0d required 1 grant to 0",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  task automatic test_single();
    logic [3:0] g_exp[6];
    logic       w_exp[6];
    logic [7:0] d;
    g_exp = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    w_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d = 8'hA1 + 8'(k);
      load(0, d, k == 3);
      push_exp(0, d);
    end
    drive_reqs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== g_exp[c] || bus.fifo_wr_en !== w_exp[c]) begin
        errors++;
        $display("FAIL single_cycle%0d: gnt %b wr_en %b required %b %b",
                 c, bus.gnt, bus.fifo_wr_en, g_exp[c], w_exp[c]);
      end
    end
    checks++;
    if (sb.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: %0d beats left busy %b required 0 0", sb.size(), bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5];
    int id;
    exp_g = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) load(i, 8'(i * 16 + k), 1'b0);
    for (int g = 0; g < 5; g++) begin
      id = g % 4;
      for (int k = 0; k < 4; k++) push_exp(id, 8'(id * 16 + ((g < 4) ? 0 : 4) + k));
    end
    drive_reqs();
    wait_done("round_robin", 200);
    rst = 1'b1;
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (g >= grant_log.size() || grant_log[g] != exp_g[g]) begin
        errors++;
        $display("FAIL rr_order%0d: grant %0d required %0d", g,
                 (g < grant_log.size()) ? grant_log[g] : -1, exp_g[g]);
      end
      if (g > 0) begin
        checks++;
        if (g >= gap_log.size() || gap_log[g] != 1) begin
          errors++;
          $display("FAIL rr_gap%0d: idle cycles %0d required 1", g,
                   (g < gap_log.size()) ? gap_log[g] : -1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load(1, 8'hB0 + 8'(k), k == 3);
      push_exp(1, 8'hB0 + 8'(k));
    end
    drive_reqs();
    wait_ack("bp", 1, 2, 20);
    // A non-owner with req_last set arrives during the stall and must wait its turn.
    load(0, 8'h55, 1'b1);
    push_exp(0, 8'h55);
    bus.fifo_full = 1'b1;
    drive_reqs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.fifo_wr_en !== 1'b0 || bus.ack !== 4'h0 || bus.gnt !== 4'b0010 ||
          bus.busy !== 1'b1 || dut.beat_cnt_q !== 4'd2) begin
        errors++;
        $display("FAIL bp_stall%0d: wr_en %b ack %b gnt %b busy %b beat_cnt %0d required 0 0000 0010 1 2",
                 c, bus.fifo_wr_en, bus.ack, bus.gnt, bus.busy, dut.beat_cnt_q);
      end
      step();
    end
    bus.fifo_full = 1'b0;
    wait_done("bp", 30);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0) begin
      errors++;
      $display("FAIL bp_grants: %0d grants, first %0d required 2 grants 1 then 0",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    for (int k = 0; k < 4; k++) load(2, 8'hC0 + 8'(k), k == 3);
    load(3, 8'hD0, 1'b0);
    load(3, 8'hD1, 1'b1);
    push_exp(2, 8'hC0);
    push_exp(3, 8'hD0);
    push_exp(3, 8'hD1);
    drive_reqs();
    wait_ack("abandon", 2, 1, 20);
    req_en[2] = 1'b0;
    drive_reqs();
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL abandon_drop: gnt %b wr_en %b required 0100 0", bus.gnt, bus.fifo_wr_en);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abandon_release: gnt %b busy %b required 0000 0", bus.gnt, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL abandon_next: gnt %b required 1000", bus.gnt);
    end
    wait_done("abandon", 20);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 4; k++) load(1, 8'hE0 + 8'(k), k == 3);
    push_exp(1, 8'hE0);
    push_exp(1, 8'hE1);
    drive_reqs();
    wait_ack("rst_mid", 1, 1, 20);
    rst = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'h0 || bus.fifo_wr_en !== 1'b0 || bus.ack !== 4'h0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_abort%0d: gnt %b wr_en %b ack %b busy %b required 0000 0 0000 0",
                 c, bus.gnt, bus.fifo_wr_en, bus.ack, bus.busy);
      end
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_beats: %0d expected beats not written required 0", sb.size());
    end
    for (int i = 0; i < 4; i++) begin
      src_data[i].delete();
      src_last[i].delete();
      load(i, 8'hF0 + 8'(i), 1'b1);
      push_exp(i, 8'hF0 + 8'(i));
    end
    drive_reqs();
    grant_log.delete();
    rst = 1'b0;
    wait_done("rst_mid_after", 40);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (g >= grant_log.size() || grant_log[g] != g) begin
        errors++;
        $display("FAIL rst_mid_order%0d: grant %0d required %0d", g,
                 (g < grant_log.size()) ? grant_log[g] : -1, g);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.fifo_full = 1'b0;
    bus.req       = 4'h0;
    bus.req_data  = 32'h0;
    bus.req_last  = 4'h0;
    req_en        = 4'hF;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abandon();
    test_reset_mid_burst();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4, legal 1..15: maximum beats one owner may write per grant.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester write request, bit i = requester i.
REQ-005 req_data  input  32  packed write data; requester i at bits [8i+7:8i].
REQ-006 req_last  input  4  bit i marks the current beat of requester i as the last of its burst.
REQ-007 gnt  output  4  registered one-hot current owner; all-zero when no owner.
REQ-008 ack  output  4  bit i high for exactly the cycles in which requester i's beat is written.
REQ-009 busy  output  1  registered; high while in state OWN.
REQ-010 fifo_full  input  1  full flag from the shared 32x8 sync FIFO.
REQ-011 fifo_wr_en  output  1  write strobe to the FIFO.
REQ-012 fifo_data  output  8  write data to the FIFO.

Function
REQ-013 Two states, IDLE and OWN; beat counter beat_cnt is 4 bits wide; last-owner pointer last_id is 2 bits wide.
REQ-014 IDLE: gnt=0, fifo_wr_en=0, ack=0.
REQ-015 IDLE with any req bit set: select the first set bit searching last_id+1, last_id+2, ... modulo 4; on the next edge gnt becomes that one-hot owner, last_id becomes its index, beat_cnt is cleared and the state becomes OWN.
REQ-016 IDLE with req=0: remain in IDLE with no state change.
REQ-017 OWN: fifo_wr_en = req[owner] AND NOT fifo_full, combinational.
REQ-018 OWN: fifo_data = the owner's req_data slice; in IDLE fifo_data = 0.
REQ-019 ack[owner] = fifo_wr_en; all other ack bits are 0.
REQ-020 Latency: a req rising in IDLE at edge t gives gnt at edge t+1, and its first possible write occurs in the cycle following edge t+1.
REQ-021 On each accepted beat, beat_cnt increments by 1.
REQ-022 fifo_full high: no write, no ack, beat_cnt held, ownership held (stall, no release).
REQ-023 Release from OWN to IDLE on the next edge when either of these holds: an accepted beat has req_last[owner]=1, or an accepted beat makes beat_cnt+1 equal BURST_MAX.
REQ-024 Release from OWN to IDLE also occurs on the next edge when req[owner]=0 (abandon); no write occurs in that cycle.
REQ-025 After any release, exactly one IDLE arbitration cycle occurs before the next grant.
REQ-026 Requests from non-owners are ignored while in OWN; req and req_last bits of non-owners have no effect.
REQ-027 With all four requesters continuously requesting, grants rotate 0,1,2,3,0,... and no requester waits more than 3 other grants.

Reset
REQ-028 rst at an edge forces state IDLE, gnt=0, busy=0, beat_cnt=0, last_id=3 (requester 0 has first priority).
REQ-029 Reset asserted during OWN aborts the burst: fifo_wr_en=0 and ack=0 from the cycle after the reset edge; rst takes priority over all other inputs.
REQ-030 While rst is high, fifo_wr_en=0 and ack=0 in every cycle after the first reset edge.

Verification
REQ-031 Single requester: req=0001, data 0xA1..0xA4, req_last on the 4th beat, fifo_full=0 -> gnt=0001 one cycle after req, four consecutive fifo_wr_en pulses carrying A1,A2,A3,A4, then gnt=0 and busy=0.
REQ-032 Round-robin: req=1111 held, req_last never set, BURST_MAX=4 -> grant order 0,1,2,3,0; each grant produces 4 writes, and each grant is separated from the next by one IDLE cycle.
REQ-033 Backpressure: fifo_full asserted for 3 cycles mid-burst -> no write and no ack during those 3 cycles, gnt held, beat_cnt unchanged; the burst resumes and completes its remaining beats.
REQ-034 Abandon: owner 2 drops req after 1 beat -> release to IDLE on the next edge; the next grant goes to requester 3 if it is requesting.
REQ-035 Reset mid-burst: rst during OWN on owner 1 -> gnt=0 and fifo_wr_en=0 on the following cycle; with req=1111 after reset, the first grant goes to requester 0.
